mudi_unit: RTL
==============

MUDI_UNIT -- requirements
Module: mudi_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, setting the BUSY duration for mult/multu.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, setting the BUSY duration for div/divu.
REQ-003 The block SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port A  input  32  operand A, the rs value, already forwarded.
REQ-006 The block SHALL have port B  input  32  operand B, the rt value, already forwarded.
REQ-007 The block SHALL have port MD_OP  input  3  operation code: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
REQ-008 The block SHALL have port START  input  1  one-cycle request qualifying MD_OP codes 001-100.
REQ-009 The block SHALL have port BUSY  output  1  high while an operation is in flight.
REQ-010 The block SHALL have port HI  output  32  HI register, consumed by the HI/LO read-select stage.
REQ-011 The block SHALL have port LO  output  32  LO register, consumed by the HI/LO read-select stage.

Function
REQ-012 The block SHALL implement FSM states IDLE, MUL and DIV, with BUSY = (state != IDLE) driven from a register.
REQ-013 In IDLE, on an edge with START=1 and MD_OP in 001-100, the block SHALL latch A, B and MD_OP, load counter with MULT_CYCLES or DIV_CYCLES, and enter MUL or DIV.
REQ-014 In MUL or DIV, each edge SHALL decrement the counter.
REQ-015 On the edge where the counter equals 1, the block SHALL write the result to HI/LO and return to IDLE, so BUSY is high for exactly N cycles and the new HI/LO is visible in the first cycle BUSY is low.
REQ-016 HI and LO SHALL hold their previous values throughout BUSY.
REQ-017 The result SHALL be computed from the latched operands only; A/B changes after the start edge SHALL have no effect.
REQ-018 mult SHALL store the signed 64-bit product of A and B as {HI,LO}; multu SHALL store the unsigned product.
REQ-019 div SHALL write the signed quotient, truncated toward zero, to LO and the remainder, with the sign of the dividend, to HI; divu SHALL do the same unsigned.
REQ-020 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-021 Division by zero (B=0) SHALL still run DIV_CYCLES of BUSY but SHALL leave HI and LO unchanged.
REQ-022 mthi/mtlo in IDLE SHALL write A to HI/LO on that edge without asserting BUSY and without needing START.
REQ-023 START and any MD_OP (including mthi/mtlo) presented while BUSY=1 SHALL be ignored; upstream stalls on START|BUSY when an MD instruction is in E.
REQ-024 START with MD_OP in {000,101,110,111} SHALL not start an operation; 101/110 still perform the move.
REQ-025 The counter width SHALL hold max(MULT_CYCLES, DIV_CYCLES); both parameters SHALL be >= 1.

Reset
REQ-026 On an edge with reset=0, the block SHALL set state=IDLE, BUSY=0, HI=0, LO=0 and counter=0, overriding every other input on that edge.
REQ-027 Reset asserted mid-operation SHALL abort it with no HI/LO write, and BUSY=0 from the next cycle.
REQ-028 The first START after reset release SHALL be accepted normally.

Verification
REQ-029 mult A=0x00000003, B=0xFFFFFFFE -> BUSY high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 multu A=0xFFFFFFFF, B=0x00000002 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=0 -> BUSY for 10 cycles, HI/LO unchanged.
REQ-032 mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle with BUSY=0; mtlo issued during a mult's BUSY -> ignored, with LO equal to the product afterwards.
REQ-033 Second START with new operands during BUSY -> ignored, only the first result appears, and BUSY is not extended.
REQ-034 reset=0 in the 3rd cycle of a div -> BUSY=0, HI=LO=0 next cycle, and no later write occurs.

Source files
------------

// File: rtl/mudi_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Operands are latched on the start edge; results land on the edge that ends BUSY.
module mudi_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MD_OP,
    input  logic        START,
    output logic        BUSY,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]        r_a;
    logic [31:0]        r_b;
    logic [2:0]         r_op;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        w_hi_nxt;
    logic [31:0]        w_lo_nxt;
    logic               r_busy;
    logic               w_accept;

    logic               w_signed_op;
    logic [63:0]        w_a_ext;
    logic [63:0]        w_b_ext;
    logic [63:0]        w_prod;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs;
    logic [31:0]        w_quo;
    logic [31:0]        w_rem;
    logic [31:0]        w_lo_div;
    logic [31:0]        w_hi_div;

    assign BUSY = r_busy;
    assign HI   = r_hi;
    assign LO   = r_lo;

    // Signed multiply: sign-extend to 64 bits, the low 64 bits of the product are exact.
    assign w_signed_op = (r_op == OP_MULT) || (r_op == OP_DIV);
    assign w_a_ext     = {{32{w_signed_op & r_a[31]}}, r_a};
    assign w_b_ext     = {{32{w_signed_op & r_b[31]}}, r_b};
    assign w_prod      = w_a_ext * w_b_ext;

    // Divide on magnitudes, then restore signs; 0x80000000/-1 wraps back to 0x80000000.
    assign w_neg_a  = w_signed_op & r_a[31];
    assign w_neg_b  = w_signed_op & r_b[31];
    assign w_dvd    = w_neg_a ? (~r_a + 32'd1) : r_a;
    assign w_dvs    = w_neg_b ? (~r_b + 32'd1) : r_b;
    assign w_quo    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd / w_dvs);
    assign w_rem    = (w_dvs == 32'd0) ? 32'd0 : (w_dvd % w_dvs);
    assign w_lo_div = (w_neg_a ^ w_neg_b) ? (~w_quo + 32'd1) : w_quo;
    assign w_hi_div = w_neg_a ? (~w_rem + 32'd1) : w_rem;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (START && (MD_OP >= OP_MULT) && (MD_OP <= OP_DIVU)) begin
                    w_accept = 1'b1;
                    if (MD_OP <= OP_MULTU) begin
                        w_state_nxt = S_MUL;
                        w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                    end else begin
                        w_state_nxt = S_DIV;
                        w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                    end
                end else if (MD_OP == OP_MTHI) begin
                    w_hi_nxt = A;
                end else if (MD_OP == OP_MTLO) begin
                    w_lo_nxt = A;
                end
            end
            S_MUL: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_hi_nxt    = w_prod[63:32];
                    w_lo_nxt    = w_prod[31:0];
                end
            end
            S_DIV: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    if (r_b != 32'd0) begin
                        w_hi_nxt = w_hi_div;
                        w_lo_nxt = w_lo_div;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_accept) begin
                r_a  <= A;
                r_b  <= B;
                r_op <= MD_OP;
            end
        end
    end

endmodule
